// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, addresses a combinational
// instruction ROM, and queues {pc, instr} pairs for decode over valid/ready.
// Redirects flush the queue and restart fetch at the new target.
module ifetch_ctrl #(
  parameter int              N        = 32,
  parameter int              AW       = 6,
  parameter int              DEPTH    = 2,
  parameter logic [N-1:0]    RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_en,
  output logic [AW-1:0] imem_addr,
  input  logic [N-1:0]  imem_q,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_pc,
  output logic [N-1:0]  out_instr,
  output logic          misalign
);

  localparam int             CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_fpc;
  logic [CW-1:0] r_count;
  logic          r_misalign;

  // Entry 0 is always the head; unused entries are kept at zero so the
  // head fields read 0 whenever the buffer is empty.
  logic [N-1:0]  r_pc    [DEPTH];
  logic [N-1:0]  r_instr [DEPTH];
  logic [N-1:0]  w_pc_nxt    [DEPTH];
  logic [N-1:0]  w_instr_nxt [DEPTH];

  logic          w_pop;
  logic          w_push;
  logic          w_bad_redirect;
  logic [CW-1:0] w_fill;

  assign out_valid      = (r_count != '0);
  assign out_pc         = r_pc[0];
  assign out_instr      = r_instr[0];
  assign misalign       = r_misalign;
  assign imem_addr      = r_fpc[AW+1:2];

  assign w_pop          = out_valid && out_ready;
  assign w_bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_push         = (r_state == S_RUN) && fetch_en && !redirect_valid &&
                          ((r_count != FULL) || w_pop);
  // Occupancy after this cycle's pop; also the slot a push lands in.
  assign w_fill         = w_pop ? (r_count - ONE) : r_count;

  // State register and sticky misalign flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state    <= S_IDLE;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) r_misalign <= w_bad_redirect;
    end
  end

  // Next-state logic; a misaligned redirect wins from any state.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch forms.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_bad_redirect)                  w_state_nxt = S_FAULT;
        else if (fetch_en && !redirect_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_bad_redirect) w_state_nxt = S_FAULT;
        else if (!fetch_en) w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        if (redirect_valid && !w_bad_redirect)
          w_state_nxt = fetch_en ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Buffer next value: shift down on pop, then write the push into the first free slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_pc_nxt[i]    = r_pc[i];
      w_instr_nxt[i] = r_instr[i];
      if (w_pop) begin
        w_pc_nxt[i]    = (i == DEPTH - 1) ? '0 : r_pc[(i + 1) % DEPTH];
        w_instr_nxt[i] = (i == DEPTH - 1) ? '0 : r_instr[(i + 1) % DEPTH];
      end
      if (w_push && (CW'(i) == w_fill)) begin
        w_pc_nxt[i]    = r_fpc;
        w_instr_nxt[i] = imem_q;
      end
    end
  end

  // Fetch PC, occupancy and buffer storage; reset and redirect both flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc   <= RESET_PC;
      r_count <= '0;
      // NOTE: the buffer storage is reset (not just the count) because the
      // head fields are outputs that must read zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_fpc   <= redirect_pc;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else begin
      if (w_push) r_fpc <= r_fpc + N'(4);
      r_count <= w_fill + {{(CW-1){1'b0}}, w_push};
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= w_pc_nxt[i];
        r_instr[i] <= w_instr_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: a ROM model feeds the DUT, the expected
// delivery order is queued per fetch stream and popped on every handshake.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  assign imem_q = 32'hC0DE_0000 | {26'd0, imem_addr};

  ifetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .misalign       (misalign)
  );

  function automatic logic [31:0] rom_word(logic [31:0] pc);
    return 32'hC0DE_0000 | {26'd0, pc[7:2]};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Replace the expected stream with n sequential PCs starting at pc.
  task automatic expect_from(logic [31:0] pc, int n);
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back(pc + 32'(4 * i));
  endtask

  // Called at a negedge with inputs set: score any handshake, then advance one cycle.
  task automatic tick();
    logic [31:0] exp_pc;
    if (out_valid && out_ready && !redirect_valid && !reset) begin
      n_total++;
      assert (sb.size() != 0) n_pass++;
      else $error("FAIL sb_underflow: observed pop of pc %h expected none", out_pc);
      if (sb.size() != 0) begin
        exp_pc = sb.pop_front();
        check("head_pc", out_pc, exp_pc);
        check("head_instr", out_instr, rom_word(exp_pc));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset          = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);

    // 1: start-up latency and streaming
    expect_from(32'h0, 16);
    reset    = 1'b0;
    fetch_en = 1'b1;
    tick();
    check("lat_c1_valid", 32'(out_valid), 32'h0);
    tick();
    check("lat_c2_valid", 32'(out_valid), 32'h1);
    tick();
    tick();

    // 2: back-pressure; head holds pc 8, fetch address freezes at word 4
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'h1);
      check("stall_pc", out_pc, 32'h8);
      check("stall_instr", out_instr, 32'hC0DE_0002);
      check("stall_addr", 32'(imem_addr), 32'h4);
    end
    out_ready = 1'b1;
    tick();
    tick();

    // 3: aligned redirect with two entries buffered
    redirect_valid = 1'b1;
    redirect_pc    = 32'h24;
    expect_from(32'h24, 8);
    tick();
    check("redir_valid", 32'(out_valid), 32'h0);
    check("redir_pc", out_pc, 32'h0);
    redirect_valid = 1'b0;
    tick();
    check("redir_refill_valid", 32'(out_valid), 32'h1);
    tick();
    tick();

    // 4: misaligned redirect, then recovery
    redirect_valid = 1'b1;
    redirect_pc    = 32'h26;
    sb.delete();
    tick();
    check("fault_misalign", 32'(misalign), 32'h1);
    check("fault_valid", 32'(out_valid), 32'h0);
    check("fault_addr", 32'(imem_addr), 32'h9);
    redirect_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("fault_hold_valid", 32'(out_valid), 32'h0);
      check("fault_hold_misalign", 32'(misalign), 32'h1);
      check("fault_hold_addr", 32'(imem_addr), 32'h9);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h34;
    expect_from(32'h34, 4);
    tick();
    check("recover_misalign", 32'(misalign), 32'h0);
    check("recover_valid", 32'(out_valid), 32'h0);
    redirect_valid = 1'b0;
    tick();
    check("recover_refill_valid", 32'(out_valid), 32'h1);
    tick();

    // 5: ROM address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hF8;
    expect_from(32'hF8, 6);
    tick();
    check("wrap_addr62", 32'(imem_addr), 32'd62);
    redirect_valid = 1'b0;
    tick();
    check("wrap_addr63", 32'(imem_addr), 32'd63);
    tick();
    check("wrap_addr0", 32'(imem_addr), 32'd0);
    tick();
    tick();

    // 6: reset with a full buffer and a redirect pending
    out_ready = 1'b0;
    tick();
    tick();
    check("full_valid", 32'(out_valid), 32'h1);
    check("full_pc", out_pc, 32'h104);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    check("r6_valid", 32'(out_valid), 32'h0);
    check("r6_pc", out_pc, 32'h0);
    check("r6_instr", out_instr, 32'h0);
    check("r6_addr", 32'(imem_addr), 32'h0);
    check("r6_misalign", 32'(misalign), 32'h0);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    expect_from(32'h0, 4);
    tick();
    check("r6_idle_valid", 32'(out_valid), 32'h0);
    tick();
    check("r6_run_valid", 32'(out_valid), 32'h1);
    tick();

    // fetch_en low: the buffered entry still drains, then fetch stops
    fetch_en = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'h0);
    check("drain_addr", 32'(imem_addr), 32'h2);
    tick();
    check("idle_addr", 32'(imem_addr), 32'h2);
    check("idle_valid", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
